vco_adc_decimator: RTL

Digital back-end for the VCO-based quantizer. It resynchronises the 1-bit `quantizer_out` stream, runs a second-order CIC (sinc²) decimator, and delivers multi-bit samples over a valid/ready handshake to the Wishbone/logic-analyzer capture path. It also drives the quantizer's active-low enable and sequences start-up warm-up.

---
 rtl/vco_adc_decimator.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/vco_adc_decimator.sv
// rtl/vco_adc_decimator.sv - VCO quantizer back-end: synchroniser, sinc^2 CIC decimator, warm-up FSM, output handshake
// Optional feature macro: VCO_DEC_EDGE_EN (integrate s2^s3 transitions instead of s2 level)
module vco_adc_decimator #(
    parameter int LOG2_DECIM = 6,
    parameter int OUT_W      = 2 * LOG2_DECIM + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             quantizer_in,
    input  logic             start,
    input  logic             stop,
    output logic             vco_en_n,
    output logic [OUT_W-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic             overrun
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WARM = 2'd1,
        RUN  = 2'd2
    } state_t;

`ifdef VCO_DEC_EDGE_EN
    localparam logic EDGE_EN = 1'b1;
`else
    localparam logic EDGE_EN = 1'b0;
`endif

    state_t                  state;
    logic                    s1, s2, s3;
    logic [OUT_W-1:0]        i1, i2, d1, d2;
    logic [LOG2_DECIM-1:0]   cnt;
    logic                    warm_seen;

    logic                    x;
    logic [OUT_W-1:0]        x_ext;
    logic [OUT_W-1:0]        i1_nxt, i2_nxt, c1, c2;
    logic                    strobe;
    logic                    load;

    // s3 only feeds x when transition detection is enabled
    assign x      = s2 ^ (s3 & EDGE_EN);
    assign x_ext  = {{(OUT_W-1){1'b0}}, x};
    assign i1_nxt = i1 + x_ext;
    assign i2_nxt = i2 + i1_nxt;
    assign c1     = i2_nxt - d1;
    assign c2     = c1 - d2;
    assign strobe = (state != IDLE) && (&cnt);
    assign load   = (state == RUN) && strobe && !stop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            s1         <= 1'b0;
            s2         <= 1'b0;
            s3         <= 1'b0;
            i1         <= '0;
            i2         <= '0;
            d1         <= '0;
            d2         <= '0;
            cnt        <= '0;
            warm_seen  <= 1'b0;
            vco_en_n   <= 1'b1;
            busy       <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            s1 <= quantizer_in;
            s2 <= s1;
            s3 <= s2;

            // A pending sample is never overwritten; the newcomer is dropped instead
            if (load) begin
                if (!dout_valid || dout_ready) begin
                    dout       <= c2;
                    dout_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (dout_ready) begin
                dout_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    i1        <= '0;
                    i2        <= '0;
                    d1        <= '0;
                    d2        <= '0;
                    cnt       <= '0;
                    warm_seen <= 1'b0;
                    if (start) begin
                        state    <= WARM;
                        vco_en_n <= 1'b0;
                        busy     <= 1'b1;
                        overrun  <= 1'b0;
                    end
                end
                WARM, RUN: begin
                    if (stop) begin
                        state     <= IDLE;
                        vco_en_n  <= 1'b1;
                        busy      <= 1'b0;
                        i1        <= '0;
                        i2        <= '0;
                        d1        <= '0;
                        d2        <= '0;
                        cnt       <= '0;
                        warm_seen <= 1'b0;
                    end else begin
                        i1  <= i1_nxt;
                        i2  <= i2_nxt;
                        cnt <= cnt + LOG2_DECIM'(1);
                        if (strobe) begin
                            d1 <= i2_nxt;
                            d2 <= c1;
                            // Two strobes flush the comb delays before real samples appear
                            if (state == WARM) begin
                                if (warm_seen) begin
                                    state <= RUN;
                                end else begin
                                    warm_seen <= 1'b1;
                                end
                            end
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    vco_en_n <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
